// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//
// Scans a 4x3 matrix keypad (rows in, columns driven), debounces presses and
// releases, and emits one registered keycode pulse per physical press for a
// lock controller.
//
// Parameters
//   SCAN_DIV        clk cycles per scan tick (2..65535)
//   DEBOUNCE_TICKS  consecutive stable ticks required for press and release
//                   (1..255)
//
// Ports
//   clk        in   1  single clock, all state on the rising edge
//   rst        in   1  asynchronous active-high reset
//   row_n      in   4  keypad rows, active-low, asynchronous to clk
//   col_n      out  3  column drive, active-low one-hot (110 = column 0)
//   key_code   out  4  keycode during the emit cycle, 4'b1111 otherwise
//   key_valid  out  1  high for exactly the emit cycle
//   key_held   out  1  high from the emit cycle until the release is debounced
// -----------------------------------------------------------------------------
module keypad_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_TICKS);

    typedef enum logic [2:0] {
        S_SCAN     = 3'd0,
        S_PRESS_DB = 3'd1,
        S_EMIT     = 3'd2,
        S_HOLD     = 3'd3,
        S_REL_DB   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_meta_q, row_sync_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [2:0]      col_n_q, col_n_d;
    logic [3:0]      row_lat_q, row_lat_d;     // one-hot (active-high) latched row
    logic [3:0]      code_lat_q, code_lat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;

    logic [3:0]      row_low;
    logic            single_low;
    logic            all_high;
    logic            tick;
    logic [CW-1:0]   cnt_inc;
    logic [1:0]      col_next;

    // Map a one-hot row and a column index onto the lock keycode.
    function automatic logic [3:0] key_lookup(input logic [3:0] row_oh,
                                              input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        r = 2'd0;
        case (row_oh)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        if (r == 2'd3) begin
            case (col)
                2'd0:    code = 4'b1110;   // '*' set passcode
                2'd1:    code = 4'b0000;   // '0'
                default: code = 4'b1101;   // '#' cancel
            endcase
        end else begin
            // Digits 1..9 laid out row-major
            code = ({2'b00, r} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    // Two-flop synchronizer; idle (pulled-up) value is all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    assign row_low    = ~row_sync_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    assign all_high   = (row_sync_q == 4'b1111);
    assign tick       = (presc_q == PRESC_LAST);
    // Saturating increment: the counter parks at the target and never wraps
    assign cnt_inc    = (cnt_q >= DB_TARGET) ? DB_TARGET : cnt_q + CW'(1);
    assign col_next   = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_lat_d  = row_lat_q;
        code_lat_d = code_lat_q;
        cnt_d      = cnt_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);

        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (single_low) begin
                        row_lat_d  = row_low;
                        code_lat_d = key_lookup(row_low, col_idx_q);
                        cnt_d      = '0;
                        state_d    = S_PRESS_DB;
                    end else begin
                        col_idx_d  = col_next;
                    end
                end
            end
            S_PRESS_DB: begin
                if (tick) begin
                    // row_lat_q is one-hot, so equality also means "single row"
                    if (row_low == row_lat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_TARGET) begin
                            state_d = S_EMIT;
                        end
                    end else begin
                        state_d   = S_SCAN;
                        col_idx_d = col_next;
                    end
                end
            end
            S_EMIT: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Column stays frozen, so keys in other columns are invisible
                if (tick && all_high) begin
                    cnt_d   = '0;
                    state_d = S_REL_DB;
                end
            end
            S_REL_DB: begin
                if (tick) begin
                    if (all_high) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_TARGET) begin
                            state_d   = S_SCAN;
                            col_idx_d = col_next;
                        end
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                state_d   = S_SCAN;
                col_idx_d = 2'd0;
            end
        endcase

        // Outputs are computed from the next state and registered, so they
        // are glitch-free and line up with the state they describe.
        col_n_d     = ~(3'b001 << col_idx_d);
        key_valid_d = (state_d == S_EMIT);
        key_code_d  = (state_d == S_EMIT) ? code_lat_q : 4'b1111;
        key_held_d  = (state_d == S_EMIT) || (state_d == S_HOLD) ||
                      (state_d == S_REL_DB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SCAN;
            presc_q     <= '0;
            col_idx_q   <= 2'd0;
            col_n_q     <= 3'b110;
            row_lat_q   <= 4'd0;
            code_lat_q  <= 4'b1111;
            cnt_q       <= '0;
            key_code_q  <= 4'b1111;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            row_lat_q   <= row_lat_d;
            code_lat_q  <= code_lat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SCAN_DIV, default 1000: clk cycles per scan tick; legal range 2..65535.
REQ-002 DEBOUNCE_TICKS, default 8: consecutive stable ticks required for press and for release; legal range 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_n  output  3  column drive, active-low one-hot.
REQ-007 key_code  output  4  lock keycode; 4'b1111 except during the emit cycle.
REQ-008 key_valid  output  1  high for exactly the emit cycle.
REQ-009 key_held  output  1  high from the emit cycle until the release is debounced.

Function
REQ-010 row_n SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert a one-cycle tick at wrap; it SHALL free-run in every state.
REQ-012 Key map (row,col) SHALL be: r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: *,0,#.
REQ-013 Codes SHALL be: digit n (1-9) = 4'(n); 0 = 4'b0000; * = 4'b1110 (set passcode); # = 4'b1101 (cancel).
REQ-014 The FSM SHALL have the states SCAN, PRESS_DB, EMIT, HOLD and REL_DB.
REQ-015 SCAN, on a tick: exactly one synchronized row low -> latch row/col, clear the debounce count, go to PRESS_DB (column frozen); otherwise advance column 0->1->2->0 (col_n 110->101->011->110).
REQ-016 SCAN, zero or more than one row low on a tick: SHALL count as no press, and the column SHALL advance.
REQ-017 PRESS_DB, on a tick: the same single row still low -> count+1; when count reaches DEBOUNCE_TICKS -> EMIT; any other row pattern -> SCAN with the column advanced.
REQ-018 EMIT SHALL last one cycle: key_code = latched code, key_valid = 1, key_held = 1; next state HOLD.
REQ-019 HOLD: column stays frozen; on a tick with all rows high -> clear the count and go to REL_DB; key presses in other columns SHALL be ignored.
REQ-020 REL_DB, on a tick: all rows high -> count+1; when count reaches DEBOUNCE_TICKS -> SCAN with the column advanced; any row low -> HOLD.
REQ-021 key_held SHALL be 1 in EMIT, HOLD and REL_DB, and 0 otherwise.
REQ-022 Latency: key_valid SHALL rise 1 clk after the DEBOUNCE_TICKS-th qualifying tick after detection; press-to-emit SHALL be (DEBOUNCE_TICKS+1) ticks + 1 clk, excluding scan wait and 2-clk sync.
REQ-023 At most one key_valid pulse SHALL occur per physical press, regardless of hold duration.
REQ-024 The debounce counter SHALL saturate and never wrap; the prescaler and counter SHALL be sized with $clog2 of the parameters.
REQ-025 Outside EMIT: key_code = 4'b1111 and key_valid = 0, registered and glitch-free.

Reset
REQ-026 On rst assertion, immediately and without clk: state = SCAN, col_n = 3'b110, key_code = 4'b1111, key_valid = 0, key_held = 0, prescaler = 0, counters = 0, synchronizer = 4'b1111.
REQ-027 Reset mid-press SHALL discard the pending key; after release of reset, a still-held key SHALL go through the full press debounce again.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-028 Reset, no keys -> col_n cycles 110,101,011 every 4 clk; key_code stays 1111, key_valid stays 0.
REQ-029 Hold r1,c1 ("5") for 40 ticks -> single key_valid pulse with key_code 4'b0101; key_held high until 3 ticks after release.
REQ-030 Press "*", then "#", then "0" sequentially -> pulses with key_code 1110, 1101, 0000 in order, one each.
REQ-031 Bounce: "7" low for 2 ticks, high 1 tick, then low for 5 ticks -> exactly one pulse with key_code 0111, from the stable segment only.
REQ-032 r0 and r2 low together in the same column -> no pulse; while "3" is held, press "1" -> no extra pulse until "3" is released.
REQ-033 rst asserted during PRESS_DB and during HOLD -> outputs reach reset values within the same cycle; no pulse until a fresh debounced press.
